// File: rtl/pixel_stream_src_pkg.sv
// rtl/pixel_stream_src_pkg.sv - shared pixel width, FSM states and counter-width helper
package pixel_stream_src_pkg;

  localparam int DEF_PIXEL_SIZE = 24;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK,
    DONE
  } state_t;

  // Bits needed to hold 0..n-1, never less than one so degenerate frames still elaborate.
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pixel_stream_src_if.sv
// rtl/pixel_stream_src_if.sv - pixel stream bundle (en, hsync, vsync, data)
interface pixel_stream_src_if
  import pixel_stream_src_pkg::*;
#(
  parameter int PIXEL_SIZE = DEF_PIXEL_SIZE
);
  logic                  en;
  logic                  hsync;
  logic                  vsync;
  logic [PIXEL_SIZE-1:0] data;

  modport master (output en, hsync, vsync, data);
  modport slave  (input  en, hsync, vsync, data);
endinterface

// File: rtl/pixel_stream_src_raster_counter.sv
// rtl/pixel_stream_src_raster_counter.sv - column/row/address/blank counters for the raster source
module raster_counter
  import pixel_stream_src_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 0,
  parameter int V_BLANK = 0,
  parameter int ADDR_W  = cnt_w(WIDTH * HEIGHT),
  parameter int COL_W   = cnt_w(WIDTH),
  parameter int ROW_W   = cnt_w(HEIGHT),
  parameter int BLANK_W = cnt_w(((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic              blank_step,
  input  logic              blank_clr,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              row_end,
  output logic              last_row,
  output logic              hblank_end,
  output logic              vblank_end
);

  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [BLANK_W-1:0] H_LAST   = BLANK_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  // Vertical blank runs one extra cycle so the last pixel clears the output stage before done.
  localparam logic [BLANK_W-1:0] V_LAST   = BLANK_W'(V_BLANK);

  logic [COL_W-1:0]   col_q,   col_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [BLANK_W-1:0] blank_q, blank_d;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    blank_d = blank_q;
    if (clr) begin
      col_d   = '0;
      row_d   = '0;
      addr_d  = '0;
      blank_d = '0;
    end else begin
      if (step) begin
        addr_d = addr_q + 1'b1;
        if (row_end) begin
          col_d = '0;
          if (!last_row) row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (blank_clr)       blank_d = '0;
      else if (blank_step) blank_d = blank_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      blank_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      blank_q <= blank_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign addr       = addr_q;
  assign row_end    = (col_q == COL_LAST);
  assign last_row   = (row_q == ROW_LAST);
  assign hblank_end = (blank_q == H_LAST);
  assign vblank_end = (blank_q == V_LAST);

endmodule

// File: rtl/pixel_stream_src.sv
// rtl/pixel_stream_src.sv - raster pixel source: frame memory reader driving the pixel stream
module pixel_stream_src
  import pixel_stream_src_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int PIXEL_SIZE = DEF_PIXEL_SIZE,
  parameter int H_BLANK    = 0,
  parameter int V_BLANK    = 0,
  parameter int ADDR_W     = cnt_w(WIDTH * HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  pixel_stream_src_if.master    px,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_W   = cnt_w(WIDTH);
  localparam int ROW_W   = cnt_w(HEIGHT);
  localparam int BLANK_W = cnt_w(((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK) + 1);

  state_t state_q, state_d;

  logic              clr, step, blank_step, blank_clr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              row_end, last_row, hblank_end, vblank_end;

  logic                  en_q,    en_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic [PIXEL_SIZE-1:0] hold_q,  hold_d;

  raster_counter #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .H_BLANK (H_BLANK),
    .V_BLANK (V_BLANK),
    .ADDR_W  (ADDR_W),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W),
    .BLANK_W (BLANK_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .step       (step),
    .blank_step (blank_step),
    .blank_clr  (blank_clr),
    .col        (col),
    .row        (row),
    .addr       (mem_addr),
    .row_end    (row_end),
    .last_row   (last_row),
    .hblank_end (hblank_end),
    .vblank_end (vblank_end)
  );

  always_comb begin
    state_d    = state_q;
    mem_rd_en  = 1'b0;
    step       = 1'b0;
    blank_step = 1'b0;
    blank_clr  = 1'b0;
    clr        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACTIVE;
      end
      ACTIVE: begin
        busy = 1'b1;
        if (!pause) begin
          mem_rd_en = 1'b1;
          step      = 1'b1;
          if (row_end) begin
            if (last_row)         state_d = VBLANK;
            else if (H_BLANK > 0) state_d = HBLANK;
          end
        end
      end
      HBLANK: begin
        busy = 1'b1;
        if (hblank_end) begin
          state_d   = ACTIVE;
          blank_clr = 1'b1;
        end else begin
          blank_step = 1'b1;
        end
      end
      VBLANK: begin
        busy = 1'b1;
        if (vblank_end) begin
          state_d   = DONE;
          blank_clr = 1'b1;
        end else begin
          blank_step = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory returns data in the cycle en is high, so data passes straight through then and holds otherwise.
  always_comb begin
    en_d    = mem_rd_en;
    hsync_d = mem_rd_en && (col == '0);
    vsync_d = mem_rd_en && (col == '0) && (row == '0);
    hold_d  = en_q ? mem_data : hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hold_q  <= hold_d;
    end
  end

  assign px.en    = en_q;
  assign px.hsync = hsync_q;
  assign px.vsync = vsync_q;
  assign px.data  = en_q ? mem_data : hold_q;

endmodule

// File: doc/pixel_stream_src.md
Name: pixel_stream_src

Overview:
- Raster pixel source: reads a stored frame from a synchronous-read frame memory and drives the pixel stream interface (en, hsync, vsync, data) that the detection pipeline's top consumes.
- Transmit end of the pixel-stream protocol; replaces bench-side streaming in hardware builds and feeds the pipeline from on-chip or external frame storage.
- One frame per start request, row-major, with optional horizontal and vertical blanking.

Parameters:
- WIDTH, 640, active pixels per row (>=1)
- HEIGHT, 480, rows per frame (>=1)
- PIXEL_SIZE, 24, bits per pixel; matches `PIXEL_SIZE
- H_BLANK, 0, idle cycles inserted after each row except the last
- V_BLANK, 0, idle cycles after the last row, before done
- ADDR_W, $clog2(WIDTH*HEIGHT), frame memory address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to stream one frame; ignored unless idle
- pause  in  1  stall; while high, no new memory read is issued
- mem_rd_en  out  1  frame memory read strobe
- mem_addr  out  ADDR_W  frame memory word address (pixel index)
- mem_data  in  PIXEL_SIZE  read data, valid exactly 1 cycle after mem_rd_en
- en  out  1  data valid this cycle
- hsync  out  1  high with the first pixel of every row
- vsync  out  1  high with the first pixel of the frame (row 0, col 0)
- data  out  PIXEL_SIZE  pixel value
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; mem_rd_en, en, hsync, vsync, busy, done = 0; mem_addr, data = 0; col/row/blank counters = 0. Reset mid-frame aborts immediately: no done pulse, and the next frame restarts at address 0.
- FSM states:
  - IDLE: on start -> ACTIVE; busy rises the next cycle.
  - ACTIVE: each cycle with pause=0, assert mem_rd_en with mem_addr = row*WIDTH+col (incrementing counter, no multiplier), then advance col.
  - Row end (col = WIDTH-1 read issued): if last row -> VBLANK (or DONE when V_BLANK=0); else if H_BLANK>0 -> HBLANK, else stay in ACTIVE with row+1, col=0.
  - HBLANK: count H_BLANK cycles -> ACTIVE. pause is ignored in blanking states.
  - VBLANK: count V_BLANK cycles -> DONE.
  - DONE: done=1 for one cycle, busy drops the same cycle, -> IDLE.
- Latency: output stage is registered from the read stage. en(t+1) = mem_rd_en(t); data(t+1) = mem_data; hsync(t+1) = mem_rd_en(t) && col(t)==0; vsync(t+1) = same && row(t)==0.
- Pause: pause=1 at cycle t suppresses the read at t, so en=0 at t+1. Counters hold. Pixels are never dropped or duplicated. data holds its last value while en=0.
- Sync pulses are asserted only with en=1 and are never stretched by pause. A row paused at col 0 still gets exactly one hsync, on its first valid pixel.
- done fires only after the final pixel has appeared on en, so VBLANK/DONE must account for the 1-cycle output-stage latency.
- start while busy or in DONE is ignored. start in IDLE on the cycle after done is accepted, allowing back-to-back frames.
- Counter widths: col $clog2(WIDTH), row $clog2(HEIGHT), blank counter wide enough for max(H_BLANK, V_BLANK); no wrap within a frame.

Decomposition:
- Shared package/global header: `PIXEL_SIZE, state enum (IDLE, ACTIVE, HBLANK, VBLANK, DONE), and the width helper for ADDR_W.
- Sub-module raster_counter: col/row/blank counters with row_end and frame_end flags. The top level keeps the FSM and the output register stage.

Test Plan:
- WIDTH=4, HEIGHT=3, blanks 0, memory holds the pixel index -> 12 consecutive en cycles with data 0..11; hsync on indices 0, 4, 8; vsync only on 0; done 1 cycle after pixel 11; busy high throughout.
- Same frame with H_BLANK=2, V_BLANK=3 -> en low exactly 2 cycles after pixels 3 and 7; done exactly 4 cycles after pixel 11.
- pause high for 3 cycles while the address is at pixel 4 (row start) -> 3-cycle en gap; data resumes at 4 with hsync=1 once; sequence still 0..11 with no repeats.
- start pulsed again mid-frame -> ignored; exactly 12 pixels and one done. start on the cycle after done -> second frame begins at address 0 with vsync.
- reset asserted at pixel 6 -> next cycle all outputs 0 and no done. A new start streams from pixel 0 with vsync=1.
- WIDTH=1, HEIGHT=1 -> a single pixel with en, hsync, and vsync all high together, then done.
